div_unit: RTL

//   Multi-cycle radix-2 restoring divider for DIV/DIVU; writes HI/LO. Sits beside ex: ex raises

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_unit_step.sv | 22 ++
 rtl/div_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared state codes and handshake levels for the multi-cycle divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// shifted partial remainder and restore when the difference goes negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_shift_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_next_o,
  output logic             quo_bit_o
);

  logic [WIDTH:0] diff;

  // The shifted remainder can exceed 2**WIDTH; its top bit alone then
  // guarantees the subtraction succeeds even though diff wraps.
  always_comb begin
    diff       = rem_shift_i - {1'b0, divisor_i};
    quo_bit_o  = rem_shift_i[WIDTH] | ~diff[WIDTH];
    rem_next_o = quo_bit_o ? diff[WIDTH-1:0] : rem_shift_i[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with start/ready handshake,
// annul and divide-by-zero handling. result_o = {remainder, quotient}.
// Optional build macro: DIV_EARLY_OUT_EN -- operands with |op1| < |op2|
// finish early with quotient 0 and remainder op1.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6    // 2**CNT_W must exceed WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   step_rem;
  logic               step_bit;
  logic [WIDTH-1:0]   quo_next;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  assign mag1      = magnitude(opdata1_i, signed_div_i);
  assign mag2      = magnitude(opdata2_i, signed_div_i);
  // The dividend is shifted out of the quotient register MSB-first.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign quo_next  = {quo_q[WIDTH-2:0], step_bit};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_shift_i (rem_shift),
    .divisor_i   (dvsr_q),
    .rem_next_o  (step_rem),
    .quo_bit_o   (step_bit)
  );

  // Next-state, iteration and result-capture logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    res_d     = res_q;
    unique case (state_q)
      DIV_FREE: begin
        if (start_i && !annul_i) begin
          dvsr_d    = mag2;
          quo_d     = mag1;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d = signed_div_i & opdata1_i[WIDTH-1];
          // Short paths pre-load the result and hop through DIV_BY_ZERO,
          // so they present ready two cycles after acceptance.
          if (opdata2_i == '0) begin
            res_d   = '0;
            state_d = DIV_BY_ZERO;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (mag1 < mag2) begin
            res_d   = {opdata1_i, {WIDTH{1'b0}}};
            state_d = DIV_BY_ZERO;
          end
`endif
          else begin
            state_d = DIV_ON;
          end
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          rem_d = step_rem;
          quo_d = quo_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            res_d   = {apply_sign(step_rem, neg_rem_q), apply_sign(quo_next, neg_quo_q)};
            state_d = DIV_END;
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d = annul_i ? DIV_FREE : DIV_END;
      end
      DIV_END: begin
        if (!start_i) state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  // Control state: FSM and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_FREE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers; their contents are only visible in DIV_END.
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvsr_q    <= dvsr_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    res_q     <= res_d;
  end

  assign ready_o  = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign result_o = (state_q == DIV_END) ? res_q : '0;

endmodule
